// File: rtl/pwd_stream_ctrl.sv
// pwd_stream_ctrl: byte-stream front end for the password checker.
//
// Frames of bytes end with the terminator byte TERM. The terminator is never
// stored and never compared. A frame either programs the password into an
// external 64x8 RAM or checks it against the RAM. The RAM is read
// combinationally in the same cycle the byte is accepted.
//
// Optional feature macro: PWD_LOCKOUT_EN. When defined, three consecutive
// failed check frames move the block into LOCKED. Only rst_ni leaves LOCKED.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   s_valid_i    input byte valid
//   s_data_i     input byte
//   s_ready_o    block can accept a byte (accept = s_valid_i && s_ready_o)
//   mode_i       1 = program frame, 0 = check frame (sampled on first byte)
//   ram_we_o     RAM write enable
//   ram_addr_o   RAM address, shared by write and read
//   ram_wdata_o  RAM write data
//   ram_rdata_i  RAM asynchronous read data for ram_addr_o
//   done_o       one-cycle pulse at the end of every frame
//   match_o      check result, valid with done_o
//   err_o        program overflow, valid with done_o
//   pwd_len_o    stored password length, 0..64
//   locked_o     lockout active (constant 0 without PWD_LOCKOUT_EN)
module pwd_stream_ctrl #(
  parameter logic [7:0] TERM = 8'h0D
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       s_valid_i,
  input  logic [7:0] s_data_i,
  output logic       s_ready_o,
  input  logic       mode_i,
  output logic       ram_we_o,
  output logic [5:0] ram_addr_o,
  output logic [7:0] ram_wdata_o,
  input  logic [7:0] ram_rdata_i,
  output logic       done_o,
  output logic       match_o,
  output logic       err_o,
  output logic [6:0] pwd_len_o,
  output logic       locked_o
);

  localparam logic [6:0] MaxLen = 7'd64;

  typedef enum logic [2:0] {
    StIdle,
    StProg,
    StCheck,
`ifdef PWD_LOCKOUT_EN
    StLocked,
`endif
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] idx_q, idx_d;
  logic       ok_q, ok_d;
  logic       pwd_valid_q, pwd_valid_d;
  logic [6:0] pwd_len_q, pwd_len_d;
  logic       fmode_q, fmode_d;
  logic       match_q, match_d;
  logic       err_q, err_d;
`ifdef PWD_LOCKOUT_EN
  logic [1:0] fail_cnt_q, fail_cnt_d;
`endif

  logic accept;
  logic prog_frame;
  logic is_term;

  assign ram_addr_o  = idx_q[5:0];
  assign ram_wdata_o = s_data_i;
  assign s_ready_o   = (state_q == StIdle) || (state_q == StProg) || (state_q == StCheck);
  assign accept      = s_valid_i && s_ready_o;
  assign is_term     = (s_data_i == TERM);
  // The first byte of a frame uses mode_i directly; later bytes use the latched mode.
  assign prog_frame  = (state_q == StIdle) ? mode_i : fmode_q;

  assign done_o    = (state_q == StDone);
  assign match_o   = match_q;
  assign err_o     = err_q;
  assign pwd_len_o = pwd_len_q;
`ifdef PWD_LOCKOUT_EN
  assign locked_o  = (state_q == StLocked);
`else
  assign locked_o  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ok_d        = ok_q;
    pwd_valid_d = pwd_valid_q;
    pwd_len_d   = pwd_len_q;
    fmode_d     = fmode_q;
    match_d     = 1'b0;
    err_d       = 1'b0;
    ram_we_o    = 1'b0;
`ifdef PWD_LOCKOUT_EN
    fail_cnt_d  = fail_cnt_q;
`endif

    case (state_q)
      StIdle, StProg, StCheck: begin
        if (accept) begin
          if (state_q == StIdle) begin
            fmode_d = mode_i;
          end
          if (prog_frame) begin
            // Any program frame invalidates the old password until it completes cleanly.
            if (state_q == StIdle) begin
              pwd_valid_d = 1'b0;
              pwd_len_d   = 7'd0;
            end
            if (!is_term) begin
              if (idx_q < MaxLen) begin
                ram_we_o = 1'b1;
                idx_d    = idx_q + 7'd1;
              end else begin
                ok_d = 1'b0;
              end
              state_d = StProg;
            end else begin
              err_d = !ok_q;
              if (ok_q) begin
                pwd_len_d   = idx_q;
                pwd_valid_d = 1'b1;
`ifdef PWD_LOCKOUT_EN
                fail_cnt_d  = 2'd0;
`endif
              end
              state_d = StDone;
            end
          end else begin
            if (!is_term) begin
              if ((idx_q >= pwd_len_q) || (s_data_i != ram_rdata_i)) begin
                ok_d = 1'b0;
              end
              if (idx_q < MaxLen) begin
                idx_d = idx_q + 7'd1;
              end
              state_d = StCheck;
            end else begin
              match_d = pwd_valid_q && ok_q && (idx_q == pwd_len_q);
`ifdef PWD_LOCKOUT_EN
              if (match_d) begin
                fail_cnt_d = 2'd0;
              end else if (fail_cnt_q != 2'd3) begin
                fail_cnt_d = fail_cnt_q + 2'd1;
              end
`endif
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        idx_d   = 7'd0;
        ok_d    = 1'b1;
        state_d = StIdle;
`ifdef PWD_LOCKOUT_EN
        if (fail_cnt_q == 2'd3) begin
          state_d = StLocked;
        end
`endif
      end
`ifdef PWD_LOCKOUT_EN
      StLocked: begin
        state_d = StLocked;
      end
`endif
      default: begin
        state_d = StIdle;
        idx_d   = 7'd0;
        ok_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      idx_q       <= 7'd0;
      ok_q        <= 1'b1;
      pwd_valid_q <= 1'b0;
      pwd_len_q   <= 7'd0;
      fmode_q     <= 1'b0;
      match_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ok_q        <= ok_d;
      pwd_valid_q <= pwd_valid_d;
      pwd_len_q   <= pwd_len_d;
      fmode_q     <= fmode_d;
      match_q     <= match_d;
      err_q       <= err_d;
    end
  end

`ifdef PWD_LOCKOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fail_cnt_q <= 2'd0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_pwd_stream_ctrl.sv
module tb_pwd_stream_ctrl;

  localparam logic [7:0] TERM = 8'h0D;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       mode;
  logic       ram_we;
  logic [5:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       done;
  logic       match;
  logic       err;
  logic [6:0] pwd_len;
  logic       locked;

  pwd_stream_ctrl #(.TERM(TERM)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .s_valid_i   (s_valid),
    .s_data_i    (s_data),
    .s_ready_o   (s_ready),
    .mode_i      (mode),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .done_o      (done),
    .match_o     (match),
    .err_o       (err),
    .pwd_len_o   (pwd_len),
    .locked_o    (locked)
  );

  always #5 clk = ~clk;

  // 64x8 RAM with asynchronous read.
  logic [7:0] mem [64];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  int n_asserts = 0;
  int n_fail    = 0;

  // Scoreboards: expected writes {addr,data} and expected frame results {match,err}.
  logic [13:0] wq [$];
  logic [1:0]  rq [$];

  // Reference model state.
  logic [7:0] fb [$];
  logic [7:0] pwd_m [$];
  bit         valid_m  = 1'b0;
  int         len_m    = 0;
  int         fails_m  = 0;
  bit         locked_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ram_we) begin
        chk("write_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          logic [13:0] e;
          e = wq.pop_front();
          chk("write_addr", 32'(ram_addr), 32'(e[13:8]));
          chk("write_data", 32'(ram_wdata), 32'(e[7:0]));
        end
      end
      if (done) begin
        chk("done_expected", 32'(rq.size() != 0), 32'd1);
        chk("ready_in_done", 32'(s_ready), 32'd0);
        if (rq.size() != 0) begin
          logic [1:0] r;
          r = rq.pop_front();
          chk("match", 32'(match), 32'(r[1]));
          chk("err", 32'(err), 32'(r[0]));
        end
      end
    end
  end

  function automatic bit same_pwd();
    if (fb.size() != pwd_m.size()) return 1'b0;
    foreach (fb[i]) if (fb[i] != pwd_m[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Sends fb (plus TERM when with_term) as one frame; mode flips after the first byte.
  task automatic send_frame(input bit prog, input int gap, input bit with_term);
    int n;
    n = fb.size();
    for (int i = 0; i <= n; i++) begin
      logic [7:0] b;
      bit acc;
      int t;
      if (i == n && !with_term) break;
      b = (i < n) ? fb[i] : TERM;
      if (gap > 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
      end
      s_valid = 1'b1;
      s_data  = b;
      mode    = (i == 0) ? prog : !prog;
      if (prog && i < n && i < 64) wq.push_back({6'(i), b});
      if (i == n) begin
        if (prog) begin
          if (n <= 64) begin
            rq.push_back(2'b00);
            valid_m = 1'b1; len_m = n; fails_m = 0;
            pwd_m = fb;
          end else begin
            rq.push_back(2'b01);
            valid_m = 1'b0; len_m = 0;
          end
        end else begin
          bit m;
          m = valid_m && same_pwd();
          rq.push_back({m, 1'b0});
`ifdef PWD_LOCKOUT_EN
          if (m) fails_m = 0;
          else begin
            fails_m++;
            if (fails_m >= 3) locked_m = 1'b1;
          end
`endif
        end
      end else if (prog && i == 0) begin
        valid_m = 1'b0; len_m = 0;
      end
      t = 0;
      do begin
        @(negedge clk); acc = s_ready;
        @(posedge clk); #1;
        t++;
      end while (!acc && t < 50);
      chk("byte_accepted", 32'(acc), 32'd1);
    end
    s_valid = 1'b0;
  endtask

  task automatic finish_frame();
    int t;
    t = 0;
    while (rq.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
    chk("done_seen", 32'(rq.size() == 0), 32'd1);
    @(posedge clk); #1;
    chk("pwd_len", 32'(pwd_len), 32'(len_m));
    chk("locked", 32'(locked), 32'(locked_m));
    chk("writes_drained", 32'(wq.size()), 32'd0);
  endtask

  task automatic set_fb(input string s);
    fb.delete();
    for (int i = 0; i < s.len(); i++) fb.push_back(s[i]);
  endtask

  task automatic do_frame(input bit prog, input string s, input int gap);
    set_fb(s);
    send_frame(prog, gap, 1'b1);
    finish_frame();
  endtask

  task automatic check_reset_outputs();
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_pwd_len", 32'(pwd_len), 32'd0);
  endtask

  task automatic pulse_reset();
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    valid_m = 1'b0; len_m = 0; fails_m = 0; locked_m = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; mode = 1'b0;
    #12 check_reset_outputs();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // No password yet: empty check frame fails.
    do_frame(1'b0, "", 0);
    // Empty password, then empty check matches.
    do_frame(1'b1, "", 0);
    do_frame(1'b0, "", 0);

    do_frame(1'b1, "abc", 0);
    do_frame(1'b0, "abc", 3);
    do_frame(1'b0, "abd", 0);
    do_frame(1'b0, "ab", 2);
    do_frame(1'b0, "abc", 0);
    do_frame(1'b0, "abcd", 0);
    do_frame(1'b0, "abc", 1);

    // Overflow: 65 bytes, only 64 writes.
    fb.delete();
    repeat (65) fb.push_back(8'h55);
    send_frame(1'b1, 0, 1'b1);
    finish_frame();
    fb.delete();
    repeat (64) fb.push_back(8'h55);
    send_frame(1'b0, 0, 1'b1);
    finish_frame();

    // Reset in the middle of a program frame.
    do_frame(1'b1, "abc", 0);
    set_fb("xy");
    send_frame(1'b1, 0, 1'b0);
    pulse_reset();
    repeat (5) begin @(negedge clk); chk("no_done_after_abort", 32'(done), 32'd0); end
    @(posedge clk); #1;
    do_frame(1'b0, "", 0);

`ifdef PWD_LOCKOUT_EN
    pulse_reset();
    do_frame(1'b1, "abc", 0);
    do_frame(1'b0, "abx", 0);
    do_frame(1'b0, "ab", 0);
    do_frame(1'b0, "abc", 0);
    do_frame(1'b0, "", 0);
    do_frame(1'b0, "zzz", 0);
    chk("not_locked_yet", 32'(locked), 32'd0);
    do_frame(1'b0, "abcd", 0);
    s_valid = 1'b1; s_data = 8'h61; mode = 1'b1;
    repeat (110) begin
      @(negedge clk);
      chk("locked_hold", 32'(locked), 32'd1);
      chk("locked_ready", 32'(s_ready), 32'd0);
    end
    @(posedge clk); #1;
    pulse_reset();
    chk("unlocked", 32'(locked), 32'd0);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
